// File: rtl/restoring_div_ctrl.sv
// restoring_div_ctrl: sequential unsigned restoring divider, one quotient bit per cycle over a sliced ripple-borrow subtractor
module restoring_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NS = WIDTH / 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] q, r, m, s, d, q_n, r_n;
    logic [CW-1:0] cnt;
    logic [NS:0] b;
    logic acc;
    assign s = {r[WIDTH-2:0], q[WIDTH-1]};
    assign b[0] = 1'b0;
    for (genvar i = 0; i < NS; i++) begin : g_slice
        assign {b[i+1], d[4*i +: 4]} = {1'b0, s[4*i +: 4]} - {1'b0, m[4*i +: 4]} - {4'b0, b[i]};
    end
    assign acc = r[WIDTH-1] | ~b[NS];
    assign r_n = acc ? d : s;
    assign q_n = {q[WIDTH-2:0], acc};
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_n = state == IDLE ? (start ? (|divisor ? RUN : DONE) : IDLE)
                : state == RUN  ? (cnt == CW'(1) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            r         <= '0;
            m         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                if (|divisor) begin
                    q   <= dividend;
                    m   <= divisor;
                    r   <= '0;
                    cnt <= CW'(WIDTH);
                    dbz <= 1'b0;
                end else begin
                    quotient  <= '1;
                    remainder <= dividend;
                    dbz       <= 1'b1;
                end
            end
            if (state == RUN) begin
                q   <= q_n;
                r   <= r_n;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    quotient  <= q_n;
                    remainder <= r_n;
                end
            end
        end
    end
endmodule
